// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types, station codes and immediate helper for the multi-lane decode queue
package decode_pkg;

    localparam int DEC_XLEN = 32;

    localparam logic [2:0] RS_ALU    = 3'd0;
    localparam logic [2:0] RS_BRANCH = 3'd1;
    localparam logic [2:0] RS_LSU    = 3'd2;
    localparam logic [2:0] RS_MULDIV = 3'd3;
    localparam logic [2:0] RS_JUMP   = 3'd4;
    localparam logic [2:0] RS_NONE   = 3'd7;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASSB  = 4'd10,
        ALU_MULDIV = 4'd11
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_src_e;

    // flags = {mem_write, branch, is_jal, is_jalr, is_lui, is_auipc, use_imm, reg_write}
    typedef struct packed {
        logic [DEC_XLEN-1:0] pc;
        alu_ctrl_e           alu_control;
        logic [DEC_XLEN-1:0] imm_ext;
        logic [2:0]          rs_station;
        logic [7:0]          flags;
        logic                illegal;
    } decoded_instr_t;

    function automatic logic [DEC_XLEN-1:0] imm_gen(input logic [31:0] ins, input imm_src_e src);
        case (src)
            IMM_I:   imm_gen = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm_gen = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm_gen = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_U:   imm_gen = {ins[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: imm_gen = '0;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode_lane.sv
// rtl/instr_decode_lane.sv - combinational single-instruction decode into a queue entry
module instr_decode_lane
    import decode_pkg::*;
(
    input  logic [DEC_XLEN-1:0] instr,
    input  logic [DEC_XLEN-1:0] pc,
    output decoded_instr_t      dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7_alt;
    logic       f7_muldiv;
    alu_ctrl_e  alu_f3;
    alu_ctrl_e  alu_ctrl;
    imm_src_e   imm_src;
    logic [2:0] rs_station;
    logic       mem_write, branch, is_jal, is_jalr, is_lui, is_auipc, use_imm, reg_write, illegal;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign f7_alt    = instr[30];
    assign f7_muldiv = (instr[31:25] == 7'b0000001);

    always_comb begin
        case (funct3)
            3'b000:  alu_f3 = ALU_ADD;
            3'b001:  alu_f3 = ALU_SLL;
            3'b010:  alu_f3 = ALU_SLT;
            3'b011:  alu_f3 = ALU_SLTU;
            3'b100:  alu_f3 = ALU_XOR;
            3'b101:  alu_f3 = f7_alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_f3 = ALU_OR;
            default: alu_f3 = ALU_AND;
        endcase
    end

    always_comb begin
        alu_ctrl   = ALU_ADD;
        imm_src    = IMM_NONE;
        rs_station = RS_NONE;
        mem_write  = 1'b0;
        branch     = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        is_lui     = 1'b0;
        is_auipc   = 1'b0;
        use_imm    = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                reg_write = 1'b1;
                if (f7_muldiv) begin
                    rs_station = RS_MULDIV;
                    alu_ctrl   = ALU_MULDIV;
                end else begin
                    rs_station = RS_ALU;
                    alu_ctrl   = (funct3 == 3'b000 && f7_alt) ? ALU_SUB : alu_f3;
                end
            end
            OPC_OP_IMM: begin
                // funct7 bit 30 is part of the immediate except for shifts, so no SUB here
                reg_write  = 1'b1;
                use_imm    = 1'b1;
                rs_station = RS_ALU;
                imm_src    = IMM_I;
                alu_ctrl   = alu_f3;
            end
            OPC_LOAD: begin
                reg_write  = 1'b1;
                use_imm    = 1'b1;
                rs_station = RS_LSU;
                imm_src    = IMM_I;
            end
            OPC_STORE: begin
                mem_write  = 1'b1;
                use_imm    = 1'b1;
                rs_station = RS_LSU;
                imm_src    = IMM_S;
            end
            OPC_BRANCH: begin
                branch     = 1'b1;
                rs_station = RS_BRANCH;
                imm_src    = IMM_B;
                alu_ctrl   = ALU_SUB;
            end
            OPC_JAL: begin
                is_jal     = 1'b1;
                reg_write  = 1'b1;
                rs_station = RS_JUMP;
                imm_src    = IMM_J;
            end
            OPC_JALR: begin
                is_jalr    = 1'b1;
                reg_write  = 1'b1;
                rs_station = RS_JUMP;
                imm_src    = IMM_I;
            end
            OPC_LUI: begin
                is_lui     = 1'b1;
                reg_write  = 1'b1;
                use_imm    = 1'b1;
                rs_station = RS_ALU;
                imm_src    = IMM_U;
                alu_ctrl   = ALU_PASSB;
            end
            OPC_AUIPC: begin
                is_auipc   = 1'b1;
                reg_write  = 1'b1;
                use_imm    = 1'b1;
                rs_station = RS_ALU;
                imm_src    = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec.pc          = pc;
        dec.alu_control = alu_ctrl;
        dec.imm_ext     = imm_gen(instr, imm_src);
        dec.rs_station  = rs_station;
        dec.flags       = {mem_write, branch, is_jal, is_jalr, is_lui, is_auipc, use_imm, reg_write};
        dec.illegal     = illegal;
    end

endmodule

// File: rtl/decode_queue_multi.sv
// rtl/decode_queue_multi.sv - multi-lane decode into a circular queue with in-order single dispatch
module decode_queue_multi
    import decode_pkg::*;
#(
    parameter int XLEN    = DEC_XLEN,
    parameter int FETCH_W = 2,
    parameter int DEPTH   = 8,
    parameter int NUM_RS  = 5
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [FETCH_W-1:0]         fetch_valid,
    input  logic [FETCH_W*XLEN-1:0]    fetch_instr,
    input  logic [XLEN-1:0]            fetch_pc,
    output logic                       fetch_ready,
    input  logic [NUM_RS-1:0]          rs_full,
    input  logic                       disp_ready,
    output logic                       disp_valid,
    output logic [XLEN-1:0]            disp_pc,
    output logic [3:0]                 disp_aluControl,
    output logic [XLEN-1:0]            disp_immExt,
    output logic [2:0]                 disp_rsStation,
    output logic [7:0]                 disp_flags,
    output logic                       disp_illegal,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    decoded_instr_t lane_dec [FETCH_W];
    decoded_instr_t entries_q [DEPTH];
    decoded_instr_t entries_d [DEPTH];
    logic [PW-1:0]  head_q, head_d;
    logic [PW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  enq_cnt;
    decoded_instr_t head_e;
    logic [7:0]     rs_full_ext;
    logic           station_ok;
    logic           fire;

    for (genvar g = 0; g < FETCH_W; g++) begin : g_lane
        instr_decode_lane u_dec (
            .instr (fetch_instr[g*XLEN +: XLEN]),
            .pc    (fetch_pc + XLEN'(4 * g)),
            .dec   (lane_dec[g])
        );
    end

    // Free space uses the registered count only; a same-cycle dispatch is not credited.
    assign fetch_ready = reset_n && !flush && ((CW'(DEPTH) - count_q) >= CW'(FETCH_W));

    assign head_e      = entries_q[head_q];
    assign rs_full_ext = 8'(rs_full);
    assign station_ok  = (head_e.rs_station == RS_NONE) || !rs_full_ext[head_e.rs_station];
    assign disp_valid  = (count_q != '0) && station_ok;
    assign fire        = disp_valid && disp_ready;

    assign disp_pc         = head_e.pc;
    assign disp_aluControl = head_e.alu_control;
    assign disp_immExt     = head_e.imm_ext;
    assign disp_rsStation  = head_e.rs_station;
    assign disp_flags      = head_e.flags;
    assign disp_illegal    = head_e.illegal;
    assign occupancy       = count_q;

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_ptr    = tail_q;
        enq_cnt   = '0;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Valid lanes are packed into consecutive slots in lane order, skipping gaps.
            if (fetch_ready) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    if (fetch_valid[i]) begin
                        entries_d[wr_ptr] = lane_dec[i];
                        wr_ptr            = wr_ptr + PW'(1);
                        enq_cnt           = enq_cnt + CW'(1);
                    end
                end
            end
            tail_d = wr_ptr;
            if (fire) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + enq_cnt - CW'(fire);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

endmodule

// File: tb/tb_decode_queue_multi.sv
// tb/tb_decode_queue_multi.sv - scoreboard bench for decode_queue_multi with a reference decoder
module tb_decode_queue_multi;
    import decode_pkg::*;

    localparam int XLEN    = 32;
    localparam int FETCH_W = 2;
    localparam int DEPTH   = 8;
    localparam int NUM_RS  = 5;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    flush;
    logic [FETCH_W-1:0]      fetch_valid;
    logic [FETCH_W*XLEN-1:0] fetch_instr;
    logic [XLEN-1:0]         fetch_pc;
    logic                    fetch_ready;
    logic [NUM_RS-1:0]       rs_full;
    logic                    disp_ready;
    logic                    disp_valid;
    logic [XLEN-1:0]         disp_pc;
    logic [3:0]              disp_aluControl;
    logic [XLEN-1:0]         disp_immExt;
    logic [2:0]              disp_rsStation;
    logic [7:0]              disp_flags;
    logic                    disp_illegal;
    logic [3:0]              occupancy;

    decode_queue_multi #(.XLEN(XLEN), .FETCH_W(FETCH_W), .DEPTH(DEPTH), .NUM_RS(NUM_RS)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .rs_full(rs_full), .disp_ready(disp_ready),
        .disp_valid(disp_valid), .disp_pc(disp_pc), .disp_aluControl(disp_aluControl),
        .disp_immExt(disp_immExt), .disp_rsStation(disp_rsStation), .disp_flags(disp_flags),
        .disp_illegal(disp_illegal), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int             checks   = 0;
    int             failures = 0;
    decoded_instr_t exp_q[$];
    int             pend     = 0;
    bit             mon_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic decoded_instr_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        decoded_instr_t d;
        alu_ctrl_e      f3tab [8];
        logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
        logic [2:0]     f3;
        logic           alt;
        logic           mw, br, jl, jr, lu, ap, ui, rw;
        f3tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        imm_i = 32'($signed(ins) >>> 20);
        imm_s = {imm_i[31:5], ins[11:7]};
        imm_b = {imm_s[31:12], ins[7], imm_s[10:1], 1'b0};
        imm_u = ins & 32'hFFFF_F000;
        imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        f3  = ins[14:12];
        alt = ins[30];
        {mw, br, jl, jr, lu, ap, ui, rw} = 8'h00;
        d = '0;
        d.pc          = pc;
        d.alu_control = ALU_ADD;
        d.rs_station  = RS_NONE;
        case (ins[6:0])
            7'b0110011: begin
                rw = 1;
                if (ins[31:25] == 7'd1) begin
                    d.rs_station = RS_MULDIV; d.alu_control = ALU_MULDIV;
                end else begin
                    d.rs_station = RS_ALU; d.alu_control = f3tab[f3];
                    if (alt && f3 == 3'd0) d.alu_control = ALU_SUB;
                    if (alt && f3 == 3'd5) d.alu_control = ALU_SRA;
                end
            end
            7'b0010011: begin
                rw = 1; ui = 1; d.rs_station = RS_ALU; d.imm_ext = imm_i; d.alu_control = f3tab[f3];
                if (alt && f3 == 3'd5) d.alu_control = ALU_SRA;
            end
            7'b0000011: begin rw = 1; ui = 1; d.rs_station = RS_LSU; d.imm_ext = imm_i; end
            7'b0100011: begin mw = 1; ui = 1; d.rs_station = RS_LSU; d.imm_ext = imm_s; end
            7'b1100011: begin br = 1; d.rs_station = RS_BRANCH; d.imm_ext = imm_b; d.alu_control = ALU_SUB; end
            7'b1101111: begin jl = 1; rw = 1; d.rs_station = RS_JUMP; d.imm_ext = imm_j; end
            7'b1100111: begin jr = 1; rw = 1; d.rs_station = RS_JUMP; d.imm_ext = imm_i; end
            7'b0110111: begin lu = 1; rw = 1; ui = 1; d.rs_station = RS_ALU; d.imm_ext = imm_u; d.alu_control = ALU_PASSB; end
            7'b0010111: begin ap = 1; rw = 1; ui = 1; d.rs_station = RS_ALU; d.imm_ext = imm_u; end
            default: d.illegal = 1'b1;
        endcase
        d.flags = {mw, br, jl, jr, lu, ap, ui, rw};
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [9];
        logic [6:0]  bad  [4];
        logic [6:0]  f7s  [3];
        logic [31:0] r;
        int          k;
        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
        bad  = '{7'h00, 7'h7F, 7'h0F, 7'h73};
        f7s  = '{7'h00, 7'h20, 7'h01};
        r = $urandom;
        k = $urandom_range(0, 10);
        if (k >= 9) return {r[31:7], bad[$urandom_range(0, 3)]};
        if (k == 0 && r[0]) r[31:25] = f7s[$urandom_range(0, 2)];
        return {r[31:7], opcs[k]};
    endfunction

    task automatic step(input logic [FETCH_W-1:0] v, input logic [FETCH_W*XLEN-1:0] ins,
                        input logic [31:0] pc, input logic rdy, input logic [NUM_RS-1:0] rsf,
                        input logic fl);
        @(posedge clk);
        #1;
        fetch_valid = v;
        fetch_instr = ins;
        fetch_pc    = pc;
        disp_ready  = rdy;
        rs_full     = rsf;
        flush       = fl;
        pend        = 0;
        if (fl) begin
            exp_q.delete();
        end else if ((DEPTH - exp_q.size()) >= FETCH_W) begin
            for (int i = 0; i < FETCH_W; i++) begin
                if (v[i]) begin
                    exp_q.push_back(ref_decode(ins[i*XLEN +: XLEN], pc + 32'(4 * i)));
                    pend++;
                end
            end
        end
    endtask

    task automatic idle(input logic rdy, input logic [NUM_RS-1:0] rsf, input int n);
        for (int i = 0; i < n; i++) step('0, {rand_instr(), rand_instr()}, 32'h0, rdy, rsf, 1'b0);
    endtask

    task automatic monitor_cycle();
        int             committed;
        bit             exp_valid;
        logic [7:0]     rsx;
        decoded_instr_t e;
        if (flush) begin
            chk("fetch_ready_during_flush", 32'(fetch_ready), 32'd0);
        end else begin
            committed = exp_q.size() - pend;
            chk("occupancy", 32'(occupancy), 32'(committed));
            chk("fetch_ready", 32'(fetch_ready), 32'((DEPTH - committed) >= FETCH_W));
            exp_valid = 1'b0;
            if (committed > 0) begin
                rsx       = 8'(rs_full);
                exp_valid = (exp_q[0].rs_station == RS_NONE) || !rsx[exp_q[0].rs_station];
            end
            chk("disp_valid", 32'(disp_valid), 32'(exp_valid));
            if (disp_valid && disp_ready && committed > 0) begin
                e = exp_q.pop_front();
                chk("disp_pc", disp_pc, e.pc);
                chk("disp_immExt", disp_immExt, e.imm_ext);
                chk("disp_aluControl", 32'(disp_aluControl), 32'(e.alu_control));
                chk("disp_rsStation", 32'(disp_rsStation), 32'(e.rs_station));
                chk("disp_flags", 32'(disp_flags), 32'(e.flags));
                chk("disp_illegal", 32'(disp_illegal), 32'(e.illegal));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) monitor_cycle();
        end
    end

    initial begin
        logic [31:0] pc;
        int          n;
        reset_n = 1'b0; flush = 1'b0; fetch_valid = '0; fetch_instr = '0;
        fetch_pc = '0; disp_ready = 1'b0; rs_full = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_disp_valid", 32'(disp_valid), 32'd0);
        chk("reset_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // single addi, then lui + sw pair
        step(2'b01, {32'h0, 32'h00500093}, 32'h100, 1'b1, '0, 1'b0);
        idle(1'b1, '0, 2);
        step(2'b11, {32'h00112023, 32'h123450B7}, 32'h200, 1'b1, '0, 1'b0);
        idle(1'b1, '0, 4);

        // fill to DEPTH with dispatch blocked, attempt a fifth group, then drain across the wrap
        for (int g = 0; g < 5; g++)
            step(2'b11, {rand_instr(), rand_instr()}, 32'h300 + 32'(8 * g), 1'b0, '0, 1'b0);
        idle(1'b0, '0, 1);
        idle(1'b1, '0, 10);

        // branch held off by its station being full
        step(2'b01, {32'h0, 32'hFE208EE3}, 32'h400, 1'b1, 5'b00010, 1'b0);
        idle(1'b1, 5'b00010, 3);
        idle(1'b1, '0, 3);

        // flush with five entries queued and a valid fetch group present
        step(2'b11, {rand_instr(), rand_instr()}, 32'h500, 1'b0, '0, 1'b0);
        step(2'b11, {rand_instr(), rand_instr()}, 32'h508, 1'b0, '0, 1'b0);
        step(2'b01, {rand_instr(), rand_instr()}, 32'h510, 1'b0, '0, 1'b0);
        step(2'b11, {rand_instr(), rand_instr()}, 32'h600, 1'b1, '0, 1'b1);
        idle(1'b1, '0, 3);

        // illegal opcode in lane 0 with every station full
        step(2'b01, {rand_instr(), 32'h0}, 32'h700, 1'b1, 5'b11111, 1'b0);
        idle(1'b1, 5'b11111, 2);
        idle(1'b1, '0, 2);

        // asynchronous reset with three entries queued
        step(2'b11, {rand_instr(), rand_instr()}, 32'h800, 1'b0, '0, 1'b0);
        step(2'b01, {rand_instr(), rand_instr()}, 32'h808, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        fetch_valid = '0;
        chk("pre_reset_occupancy", 32'(occupancy), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("midreset_disp_valid", 32'(disp_valid), 32'd0);
        chk("midreset_fetch_ready", 32'(fetch_ready), 32'd0);
        exp_q.delete();
        pend = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("postreset_occupancy", 32'(occupancy), 32'd0);
        chk("postreset_fetch_ready", 32'(fetch_ready), 32'd1);
        mon_en = 1'b1;

        // randomized traffic
        pc = 32'h1000;
        for (int c = 0; c < 400; c++) begin
            step(FETCH_W'($urandom_range(0, 3)), {rand_instr(), rand_instr()}, pc,
                 $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 3) == 0) ? NUM_RS'($urandom) : '0,
                 $urandom_range(0, 39) == 0);
            pc = pc + 32'h10;
        end

        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            idle(1'b1, '0, 1);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        idle(1'b1, '0, 1);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
